fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage feeding decode and the register-file datapath of the processor. Holds the PC and issues word reads to instruction memory over a req/ack handshake tolerant of variable latency. Presents one instruction at a time to decode over valid/ready. Accepts branch/jump redirects, which flush any in-flight or held instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, PC / memory address width

Ports:
clk  in  1  single clock; all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
imem_req  out  1  read request to instruction memory
imem_addr  out  ADDR_W  byte address of the requested word; always equals pc
imem_ack  in  1  read data valid this cycle; meaningful only while imem_req=1
imem_rdata  in  32  instruction word, valid with imem_ack
inst_valid  out  1  inst/inst_pc hold a valid instruction
inst_ready  in  1  decode accepts the instruction this cycle
inst  out  32  fetched instruction word
inst_pc  out  ADDR_W  address inst was fetched from
inst_pc_plus4  out  ADDR_W  inst_pc+4, for link/branch use
redirect  in  1  branch/jump taken; load redirect_target
redirect_target  in  ADDR_W  new PC
fetch_fault  out  1  misaligned redirect trap (see Optional Feature)

Behaviour:
- Reset (reset_n=0, async): state=IDLE, pc=RESET_PC, pending target=0, imem_req=0, inst_valid=0, inst=0, inst_pc=0, inst_pc_plus4=0, fetch_fault=0. Any memory ack outstanding at reset is ignored.
- States: IDLE, FETCH, HOLD, DISCARD. imem_req=1 only in FETCH and DISCARD. imem_addr=pc, held stable while imem_req=1 until ack.
- IDLE: next edge -> FETCH unconditionally. On redirect, pc<=target.
- FETCH without ack or redirect: stay FETCH.
- FETCH, imem_ack=1, no redirect: inst<=imem_rdata, inst_pc<=pc, inst_pc_plus4<=pc+4, pc<=pc+4, inst_valid<=1, -> HOLD. Latency: ack cycle to inst_valid high is 1 cycle.
- FETCH, redirect and imem_ack in the same cycle: data dropped, pc<=target, stay FETCH.
- FETCH, redirect without ack: pending<=target, -> DISCARD. The old request stays asserted at the same address until acked.
- DISCARD: a further redirect overwrites pending (last wins). On imem_ack, data is dropped, pc<=pending (or the same-cycle redirect target), -> FETCH.
- HOLD: inst_valid=1, outputs stable until handshake.
  - inst_ready=1: -> FETCH, inst_valid<=0.
  - redirect: pc<=target, inst_valid<=0, -> FETCH. A same-cycle inst_ready still counts as acceptance.
- Throughput: at most 1 instruction per 2 cycles with zero-wait memory. Each instruction is delivered exactly once and in PC order between redirects.
- PC arithmetic is modulo 2^ADDR_W: 32'hFFFF_FFFC + 4 = 0.
- Without the macro: redirect_target[1:0] is forced to 2'b00.

Optional Feature:
FETCH_MISALIGN_TRAP_EN
- Defined: a redirect whose target[1:0]!=0 sets fetch_fault=1 (sticky until reset), forces inst_valid=0 and imem_req=0, and freezes state. An outstanding request is abandoned and its ack ignored.
- Undefined: fetch_fault tied 0; low two target bits cleared silently.

Test Plan:
- Reset release, zero-wait memory returning 32'h3410_00F0 at 0, 32'h3411_000F at 4; inst_ready=1 -> imem_addr sequence 0,4,8; inst_valid pulses with inst_pc 0 then 4; inst_pc_plus4 4 then 8.
- imem_ack delayed 3 cycles, inst_ready held 0 for 5 cycles -> imem_addr stable during wait; inst/inst_pc unchanged while held; no request issued in HOLD.
- Redirect to 32'h40 in FETCH, ack 2 cycles later -> data from the old address never appears on inst; next request at 32'h40. Second redirect to 32'h80 during DISCARD -> fetch resumes at 32'h80.
- Redirect to 32'h100 in the same cycle as ack -> ack data dropped, next imem_addr=32'h100; redirect in HOLD -> inst_valid low next cycle.
- RESET_PC=32'hFFFF_FFFC -> first inst_pc FFFF_FFFC, inst_pc_plus4=0, next imem_addr=0.
- reset_n pulsed low mid-DISCARD -> all outputs reset immediately; late ack ignored. With FETCH_MISALIGN_TRAP_EN, redirect to 32'h42 -> fetch_fault=1, imem_req=0 thereafter; without it, fetch resumes at 32'h40.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, decode and redirect signals of the fetch stage.
interface fetch_unit_if #(parameter int ADDR_W = 32);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst;
    logic [ADDR_W-1:0] inst_pc;
    logic [ADDR_W-1:0] inst_pc_plus4;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_target;
    logic              fetch_fault;
    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc_plus4, fetch_fault,
        input  imem_ack, imem_rdata, inst_ready, redirect, redirect_target
    );
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc_plus4, fetch_fault,
        output imem_ack, imem_rdata, inst_ready, redirect, redirect_target
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC + variable-latency imem req/ack fetch, one instruction at a time to decode.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects via fetch_fault.
module fetch_unit #(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          reset_n,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pend_q, pend_d, ipc_q, ipc_d, ipc4_q, ipc4_d;
    logic [31:0]       inst_q, inst_d;
    logic              valid_q, valid_d, fault_q, trap;
    logic [ADDR_W-1:0] tgt;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign tgt  = bus.redirect_target;
    assign trap = fault_q || (bus.redirect && |bus.redirect_target[1:0]);
`else
    assign tgt  = bus.redirect_target & ~ADDR_W'(3);
    assign trap = 1'b0;
`endif
    assign bus.imem_req      = (state_q == FETCH || state_q == DISCARD) && !fault_q;
    assign bus.imem_addr     = pc_q;
    assign bus.inst_valid    = valid_q;
    assign bus.inst          = inst_q;
    assign bus.inst_pc       = ipc_q;
    assign bus.inst_pc_plus4 = ipc4_q;
    assign bus.fetch_fault   = fault_q;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        inst_d  = inst_q;
        ipc_d   = ipc_q;
        ipc4_d  = ipc4_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (bus.redirect) pc_d = tgt;
            end
            FETCH: begin
                if (bus.redirect) begin
                    if (bus.imem_ack) pc_d = tgt;
                    else begin
                        pend_d  = tgt;
                        state_d = DISCARD;
                    end
                end else if (bus.imem_ack) begin
                    inst_d  = bus.imem_rdata;
                    ipc_d   = pc_q;
                    ipc4_d  = pc_q + ADDR_W'(4);
                    pc_d    = pc_q + ADDR_W'(4);
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.redirect || bus.inst_ready) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
                if (bus.redirect) pc_d = tgt;
            end
            DISCARD: begin
                if (bus.redirect) pend_d = tgt;
                if (bus.imem_ack) begin
                    pc_d    = bus.redirect ? tgt : pend_q;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            inst_q  <= '0;
            ipc_q   <= '0;
            ipc4_q  <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (trap) begin
            // trapped: everything frozen, instruction withdrawn
            fault_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            inst_q  <= inst_d;
            ipc_q   <= ipc_d;
            ipc4_q  <= ipc4_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit handshakes, redirects, wrap and reset.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rst_w_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    always #5 clk = ~clk;
    fetch_unit_if #(.ADDR_W(32)) bus ();
    fetch_unit_if #(.ADDR_W(32)) bus_w ();
    fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (.clk(clk), .reset_n(rst_w_n), .bus(bus_w));
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a == 32'h0 ? 32'h3410_00F0 : a == 32'h4 ? 32'h3411_000F : {16'hC0DE, a[15:0]};
    endfunction
    assign bus.imem_rdata   = mem_word(bus.imem_addr);
    assign bus_w.imem_rdata = mem_word(bus_w.imem_addr);
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        repeat (2) step();
        n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", bus.imem_req); end
        n_chk++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", bus.inst_valid); end
        n_chk++; if (bus.inst !== 32'h0 || bus.inst_pc !== 32'h0 || bus.inst_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got %h/%h/%h exp 0/0/0", bus.inst, bus.inst_pc, bus.inst_pc_plus4); end
        n_chk++; if (bus.imem_addr !== 32'h0 || bus.fetch_fault !== 1'b0) begin n_fail++; $display("FAIL rst_addr_fault: got %h/%b exp 0/0", bus.imem_addr, bus.fetch_fault); end
        n_chk++; if (bus_w.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL rst_pc_param: got %h exp fffffffc", bus_w.imem_addr); end
        reset_n = 1'b1;
    endtask
    task automatic test_basic;
        bus.imem_ack = 1'b1; bus.inst_ready = 1'b1;
        step();
        n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL basic_req0: got %b/%h exp 1/0", bus.imem_req, bus.imem_addr); end
        step();
        n_chk++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst !== 32'h3410_00F0) begin n_fail++; $display("FAIL basic_inst0: got %b/%h/%h exp 1/0/341000f0", bus.inst_valid, bus.inst_pc, bus.inst); end
        n_chk++; if (bus.inst_pc_plus4 !== 32'h4 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL basic_pc4_0: got %h/%b exp 4/0", bus.inst_pc_plus4, bus.imem_req); end
        step();
        n_chk++; if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h4 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL basic_req4: got %b/%h/%b exp 0/4/1", bus.inst_valid, bus.imem_addr, bus.imem_req); end
        step();
        n_chk++; if (bus.inst_pc !== 32'h4 || bus.inst !== 32'h3411_000F || bus.inst_pc_plus4 !== 32'h8) begin n_fail++; $display("FAIL basic_inst4: got %h/%h/%h exp 4/3411000f/8", bus.inst_pc, bus.inst, bus.inst_pc_plus4); end
        step();
        n_chk++; if (bus.imem_addr !== 32'h8 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL basic_req8: got %h/%b exp 8/1", bus.imem_addr, bus.imem_req); end
        bus.imem_ack = 1'b0; bus.inst_ready = 1'b0;
    endtask
    task automatic test_wait;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8 || bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL wait_addr%0d: got %b/%h/%b exp 1/8/0", i, bus.imem_req, bus.imem_addr, bus.inst_valid); end
        end
        bus.imem_ack = 1'b1;
        step();
        bus.imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_chk++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h8 || bus.inst !== 32'hC0DE_0008 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL hold%0d: got %b/%h/%h/%b exp 1/8/c0de0008/0", i, bus.inst_valid, bus.inst_pc, bus.inst, bus.imem_req); end
        end
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        n_chk++; if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'hC) begin n_fail++; $display("FAIL hold_release: got %b/%h exp 0/c", bus.inst_valid, bus.imem_addr); end
    endtask
    task automatic test_redirect_discard;
        bus.redirect = 1'b1; bus.redirect_target = 32'h40;
        step();
        bus.redirect = 1'b0;
        n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) begin n_fail++; $display("FAIL disc_hold_addr: got %b/%h exp 1/c", bus.imem_req, bus.imem_addr); end
        step();
        n_chk++; if (bus.imem_addr !== 32'hC || bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL disc_wait: got %h/%b exp c/0", bus.imem_addr, bus.inst_valid); end
        bus.imem_ack = 1'b1;
        step();
        n_chk++; if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h40) begin n_fail++; $display("FAIL disc_resume: got %b/%h exp 0/40", bus.inst_valid, bus.imem_addr); end
        step();
        n_chk++; if (bus.inst_pc !== 32'h40 || bus.inst !== 32'hC0DE_0040) begin n_fail++; $display("FAIL disc_inst: got %h/%h exp 40/c0de0040", bus.inst_pc, bus.inst); end
        bus.imem_ack = 1'b0; bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        bus.redirect = 1'b1; bus.redirect_target = 32'h60;
        step();
        bus.redirect_target = 32'h80;
        step();
        bus.redirect = 1'b0;
        n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h44) begin n_fail++; $display("FAIL disc2_addr: got %b/%h exp 1/44", bus.imem_req, bus.imem_addr); end
        bus.imem_ack = 1'b1;
        step();
        n_chk++; if (bus.imem_addr !== 32'h80) begin n_fail++; $display("FAIL disc2_last_wins: got %h exp 80", bus.imem_addr); end
        step();
        n_chk++; if (bus.inst_pc !== 32'h80 || bus.inst !== 32'hC0DE_0080) begin n_fail++; $display("FAIL disc2_inst: got %h/%h exp 80/c0de0080", bus.inst_pc, bus.inst); end
        bus.imem_ack = 1'b0; bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
    endtask
    task automatic test_redirect_ack;
        bus.imem_ack = 1'b1; bus.redirect = 1'b1; bus.redirect_target = 32'h100;
        step();
        bus.redirect = 1'b0;
        n_chk++; if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h100 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL racc_drop: got %b/%h/%b exp 0/100/1", bus.inst_valid, bus.imem_addr, bus.imem_req); end
        step();
        n_chk++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h100) begin n_fail++; $display("FAIL racc_inst: got %b/%h exp 1/100", bus.inst_valid, bus.inst_pc); end
        bus.imem_ack = 1'b0; bus.redirect = 1'b1; bus.redirect_target = 32'h200;
        step();
        bus.redirect = 1'b0;
        n_chk++; if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h200) begin n_fail++; $display("FAIL hold_redirect: got %b/%h exp 0/200", bus.inst_valid, bus.imem_addr); end
    endtask
    task automatic test_wrap;
        rst_w_n = 1'b1;
        step();
        n_chk++; if (bus_w.imem_req !== 1'b1 || bus_w.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req: got %b/%h exp 1/fffffffc", bus_w.imem_req, bus_w.imem_addr); end
        step();
        n_chk++; if (bus_w.inst_pc !== 32'hFFFF_FFFC || bus_w.inst_pc_plus4 !== 32'h0 || bus_w.inst !== 32'hC0DE_FFFC) begin n_fail++; $display("FAIL wrap_inst: got %h/%h/%h exp fffffffc/0/c0defffc", bus_w.inst_pc, bus_w.inst_pc_plus4, bus_w.inst); end
        n_chk++; if (bus_w.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next: got %h exp 0", bus_w.imem_addr); end
    endtask
    task automatic test_reset_mid_discard;
        bus.redirect = 1'b1; bus.redirect_target = 32'h300;
        step();
        bus.redirect = 1'b0;
        n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin n_fail++; $display("FAIL mrst_pre: got %b/%h exp 1/200", bus.imem_req, bus.imem_addr); end
        #2 reset_n = 1'b0;
        #1;
        n_chk++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || bus.inst_valid !== 1'b0 || bus.inst_pc !== 32'h0) begin n_fail++; $display("FAIL mrst_async: got %b/%h/%b/%h exp 0/0/0/0", bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst_pc); end
        bus.imem_ack = 1'b1;
        step();
        reset_n = 1'b1;
        step();
        n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_restart: got %b/%h/%b exp 1/0/0", bus.imem_req, bus.imem_addr, bus.inst_valid); end
        step();
        n_chk++; if (bus.inst_pc !== 32'h0 || bus.inst !== 32'h3410_00F0) begin n_fail++; $display("FAIL mrst_inst: got %h/%h exp 0/341000f0", bus.inst_pc, bus.inst); end
        bus.imem_ack = 1'b0; bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
    endtask
    task automatic test_misalign;
        bus.imem_ack = 1'b1; bus.redirect = 1'b1; bus.redirect_target = 32'h42;
        step();
        bus.redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        n_chk++; if (bus.fetch_fault !== 1'b1 || bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL trap_set: got %b/%b/%b exp 1/0/0", bus.fetch_fault, bus.imem_req, bus.inst_valid); end
        step();
        n_chk++; if (bus.fetch_fault !== 1'b1 || bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL trap_sticky: got %b/%b/%b exp 1/0/0", bus.fetch_fault, bus.imem_req, bus.inst_valid); end
`else
        n_chk++; if (bus.fetch_fault !== 1'b0 || bus.imem_addr !== 32'h40 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL misalign_mask: got %b/%h/%b exp 0/40/1", bus.fetch_fault, bus.imem_addr, bus.imem_req); end
        step();
        n_chk++; if (bus.inst_pc !== 32'h40 || bus.inst !== 32'hC0DE_0040 || bus.fetch_fault !== 1'b0) begin n_fail++; $display("FAIL misalign_inst: got %h/%h/%b exp 40/c0de0040/0", bus.inst_pc, bus.inst, bus.fetch_fault); end
`endif
        bus.imem_ack = 1'b0;
    endtask
    initial begin
        bus.imem_ack = 1'b0; bus.inst_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_target = '0;
        bus_w.imem_ack = 1'b1; bus_w.inst_ready = 1'b1; bus_w.redirect = 1'b0; bus_w.redirect_target = '0;
        test_reset();
        test_basic();
        test_wait();
        test_redirect_discard();
        test_redirect_ack();
        test_wrap();
        test_reset_mid_discard();
        test_misalign();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
